// File: rtl/pipe_stage_reg_pkg.sv
// Shared core definitions for pipeline boundary registers.
// Control field layout, bubble pattern, per-boundary widths.
package pipe_stage_reg_pkg;

  localparam int CTRL_W = 8;

  localparam int MEM_WRT_IDX  = 0;
  localparam int READ_EN_IDX  = 1;
  localparam int WB_SEL_LO    = 2;
  localparam int WB_SEL_HI    = 3;
  localparam int DUMP_IDX     = 7;

  localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

  localparam int F2D_DATA_W = 32;
  localparam int D2X_DATA_W = 96;
  localparam int X2M_DATA_W = 48;
  localparam int M2W_DATA_W = 48;

  typedef enum logic [1:0] {
    SEL_LOAD  = 2'd0,
    SEL_HOLD  = 2'd1,
    SEL_FLUSH = 2'd2
  } sel_e;

  function automatic logic [CTRL_W-1:0] squash(
    input logic              vld,
    input logic [CTRL_W-1:0] c,
    input logic [CTRL_W-1:0] nop
  );
    return vld ? c : nop;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_dff_en.sv
// Register with load enable and sync reset to RST_VAL.
// Ports: clk, rst, en, d -> q.
module dff_en #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst)
      q <= RST_VAL;
    else if (en)
      q <= d;
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage register: stall/flush/valid/halt + bubble count.
// In: clk rst stall flush validX dataX ctrlX. Out: validM dataM ctrlM halted bubble_cnt.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int                 DATA_W   = 48,
  parameter int                 CTRL_W   = 8,
  parameter logic [CTRL_W-1:0]  CTRL_NOP = '0,
  parameter bit                 DATA_CLR = 1'b0,
  parameter int                 HALT_IDX = 0,
  parameter int                 CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              validX,
  input  logic [DATA_W-1:0] dataX,
  input  logic [CTRL_W-1:0] ctrlX,
  output logic              validM,
  output logic [DATA_W-1:0] dataM,
  output logic [CTRL_W-1:0] ctrlM,
  output logic              halted,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  sel_e              sel;
  logic              en;
  logic              valid_d;
  logic [DATA_W-1:0] data_d;
  logic [CTRL_W-1:0] ctrl_d;
  logic              halt_d;
  logic              cap_bubble;

  always_comb begin
    sel = SEL_LOAD;
    if (flush)
      sel = SEL_FLUSH;
    else if (stall || halted)
      sel = SEL_HOLD;
  end

  assign en = (sel != SEL_HOLD);

  always_comb begin
    valid_d    = 1'b0;
    data_d     = dataM;
    ctrl_d     = CTRL_NOP;
    halt_d     = 1'b0;
    cap_bubble = 1'b0;
    unique case (1'b1)
      (sel == SEL_FLUSH): begin
        if (DATA_CLR)
          data_d = '0;
        cap_bubble = 1'b1;
      end
      (sel == SEL_HOLD): begin
        valid_d = validM;
        ctrl_d  = ctrlM;
        halt_d  = halted;
      end
      default: begin
        valid_d = validX;
        // Invalid entries still carry data unless cleared, but never control.
        data_d  = (!validX && DATA_CLR) ? '0 : dataX;
        ctrl_d  = squash(validX, ctrlX, CTRL_NOP);
        halt_d  = validX && ctrlX[HALT_IDX];
        cap_bubble = !validX;
      end
    endcase
  end

  dff_en #(.W(1), .RST_VAL(1'b0)) u_valid (
    .clk(clk), .rst(rst), .en(en),
    .d(valid_d), .q(validM)
  );

  dff_en #(.W(DATA_W), .RST_VAL('0)) u_data (
    .clk(clk), .rst(rst), .en(en),
    .d(data_d), .q(dataM)
  );

  dff_en #(.W(CTRL_W), .RST_VAL(CTRL_NOP)) u_ctrl (
    .clk(clk), .rst(rst), .en(en),
    .d(ctrl_d), .q(ctrlM)
  );

  dff_en #(.W(1), .RST_VAL(1'b0)) u_halt (
    .clk(clk), .rst(rst), .en(en),
    .d(halt_d), .q(halted)
  );

  always_ff @(posedge clk) begin
    if (rst)
      bubble_cnt <= '0;
    else if (cap_bubble && bubble_cnt != CNT_MAX)
      bubble_cnt <= bubble_cnt + 1'b1;
  end

endmodule
